// File: rtl/branch_seq_ctrl.sv
// ---------------------------------------------------------------------------
// branch_seq_ctrl
//
// Sequences the ID-stage branch comparator of the 16-bit 5-stage pipeline.
// A decoded branch is accepted in IDLE, then waits in HOLD while a compare
// operand is still being produced. It then spends exactly one RESOLVE cycle
// driving the comparator op and sampling jmpTrue. A taken branch redirects
// the PC and squashes the wrong-path fetch for FLUSH_CYCLES cycles.
// Resolved and taken branches are counted with saturating counters. A
// sticky flag records any branch abandoned because its operands never
// arrived.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   brValid    ID stage presents a branch this cycle
//   brOpIn     branch type: 00 none, 01 lt, 10 eq, 11 gt
//   brTarget   branch target, valid with brValid
//   opBusy     a compare operand is still in flight in EX/MEM
//   jmpTrue    comparator result (combinational from cmpOp)
//   cmpOp      op driven to the comparator (00 outside RESOLVE)
//   stall      freeze PC and IF/ID
//   flush      squash the IF/ID instruction
//   pcSel      select pcTarget as the next PC
//   pcTarget   latched branch target
//   brCount    resolved branches, saturating
//   takenCount taken branches, saturating
//   hazErr     sticky HOLD-timeout flag
// ---------------------------------------------------------------------------
module branch_seq_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned HOLD_LIMIT   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        brValid,
    input  logic [1:0]  brOpIn,
    input  logic [15:0] brTarget,
    input  logic        opBusy,
    input  logic        jmpTrue,
    output logic [1:0]  cmpOp,
    output logic        stall,
    output logic        flush,
    output logic        pcSel,
    output logic [15:0] pcTarget,
    output logic [15:0] brCount,
    output logic [15:0] takenCount,
    output logic        hazErr
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_FLUSH   = 2'd3
    } state_t;

    // The last count value of each counter is the one at which the
    // state is left. The counters start at zero on entry, so the last
    // value is the limit minus one.
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_LIMIT - 1);
    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] target_q, target_d;
    logic [7:0]  holdCnt_q, holdCnt_d;
    logic [2:0]  flushCnt_q, flushCnt_d;
    logic [15:0] brCount_q, brCount_d;
    logic [15:0] takenCount_q, takenCount_d;
    logic        hazErr_q, hazErr_d;

    // Next-state and output decode. Every variable gets its hold or
    // idle value first, so each state only has to state what changes.
    // stall, pcSel and cmpOp are combinational so the front end freezes
    // in the very cycle a branch is accepted. This also lets the redirect
    // happen in the same cycle the comparator answers. A branch that
    // times out in HOLD is dropped without touching the counters. An
    // operand arriving in the timeout cycle still wins, so such a branch
    // is resolved.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        target_d     = target_q;
        holdCnt_d    = holdCnt_q;
        flushCnt_d   = flushCnt_q;
        brCount_d    = brCount_q;
        takenCount_d = takenCount_q;
        hazErr_d     = hazErr_q;
        stall        = 1'b0;
        pcSel        = 1'b0;
        cmpOp        = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (brValid && (brOpIn != 2'b00)) begin
                    stall     = 1'b1;
                    op_d      = brOpIn;
                    target_d  = brTarget;
                    holdCnt_d = 8'd0;
                    state_d   = opBusy ? ST_HOLD : ST_RESOLVE;
                end
            end
            ST_HOLD: begin
                stall = 1'b1;
                if (!opBusy) begin
                    holdCnt_d = 8'd0;
                    state_d   = ST_RESOLVE;
                end else if (holdCnt_q == HOLD_LAST) begin
                    holdCnt_d = 8'd0;
                    hazErr_d  = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    holdCnt_d = holdCnt_q + 8'd1;
                end
            end
            ST_RESOLVE: begin
                stall     = 1'b1;
                cmpOp     = op_q;
                brCount_d = (brCount_q == 16'hFFFF) ? brCount_q : brCount_q + 16'd1;
                if (jmpTrue) begin
                    pcSel        = 1'b1;
                    takenCount_d = (takenCount_q == 16'hFFFF) ? takenCount_q : takenCount_q + 16'd1;
                    flushCnt_d   = 3'd0;
                    state_d      = ST_FLUSH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (flushCnt_q == FLUSH_LAST) begin
                    flushCnt_d = 3'd0;
                    state_d    = ST_IDLE;
                end else begin
                    flushCnt_d = flushCnt_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register. Reset is synchronous and overrides whatever the
    // sequencer is doing, including a branch parked in HOLD or FLUSH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= 2'b00;
            target_q     <= 16'h0000;
            holdCnt_q    <= 8'd0;
            flushCnt_q   <= 3'd0;
            brCount_q    <= 16'h0000;
            takenCount_q <= 16'h0000;
            hazErr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            target_q     <= target_d;
            holdCnt_q    <= holdCnt_d;
            flushCnt_q   <= flushCnt_d;
            brCount_q    <= brCount_d;
            takenCount_q <= takenCount_d;
            hazErr_q     <= hazErr_d;
        end
    end

    assign flush      = (state_q == ST_FLUSH);
    assign pcTarget   = target_q;
    assign brCount    = brCount_q;
    assign takenCount = takenCount_q;
    assign hazErr     = hazErr_q;

endmodule

// File: doc/branch_seq_ctrl.md
Name: branch_seq_ctrl

Overview:
Sequencer for the ID-stage branch comparator in the 16-bit 5-stage pipeline. Accepts decoded branch requests and holds the front end while compare operands are pending. Drives the comparator's 2-bit op for exactly one resolve cycle, samples its jmpTrue result, redirects the PC and flushes the wrong-path fetch. Also keeps branch and taken counters, and a sticky hazard-timeout flag.

Parameters:
FLUSH_CYCLES, 1, number of cycles flush stays asserted after a taken branch (legal range 1-7).
HOLD_LIMIT, 15, maximum HOLD cycles before the branch is abandoned (legal range 1-255).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous active-high reset.
brValid  input  1  ID stage presents a branch instruction this cycle.
brOpIn  input  2  branch type: 00 none, 01 less-than, 10 equal, 11 greater-than.
brTarget  input  16  branch target address, valid with brValid.
opBusy  input  1  a compare operand (regIn or reg15In) is still being produced by EX/MEM.
jmpTrue  input  1  comparator result, combinational from cmpOp.
cmpOp  output  2  branch op driven to the comparator.
stall  output  1  freeze PC and IF/ID.
flush  output  1  squash the IF/ID instruction.
pcSel  output  1  select pcTarget as next PC.
pcTarget  output  16  latched branch target.
brCount  output  16  resolved branches, saturating.
takenCount  output  16  taken branches, saturating.
hazErr  output  1  sticky: a branch was abandoned on HOLD timeout.

Behaviour:
- Reset (rst=1 at clk edge): state IDLE. Latched op, target, hold counter, flush counter, brCount, takenCount and hazErr all clear to 0. All outputs read 0 in the cycle after reset. Reset overrides any state, including mid-HOLD and mid-FLUSH.
- States: IDLE, HOLD, RESOLVE, FLUSH. Encoding is free.
- Accept condition: state IDLE && brValid && brOpIn != 00.
  - On accept, latch brOpIn and brTarget.
  - Next state is HOLD if opBusy=1 in that cycle, else RESOLVE.
  - brValid with brOpIn=00 is ignored: no stall, no count.
- IDLE -> HOLD/RESOLVE: stall=1 combinationally in the accept cycle.
- HOLD:
  - stall=1.
  - Hold counter increments each cycle.
  - opBusy=0 -> RESOLVE; the hold counter clears.
  - Counter reaching HOLD_LIMIT with opBusy still 1 -> set hazErr, go to IDLE, branch dropped (not counted, no redirect).
  - opBusy=0 takes priority over timeout in the same cycle.
- RESOLVE (always exactly 1 cycle):
  - cmpOp = latched op; cmpOp=00 in every other state.
  - stall=1.
  - brCount increments, saturating at 16'hFFFF.
  - jmpTrue=1: pcSel=1 combinationally this cycle, takenCount increments (saturating), next state FLUSH.
  - jmpTrue=0: pcSel=0, next state IDLE.
- FLUSH:
  - flush=1 and stall=0 for FLUSH_CYCLES consecutive cycles, then IDLE.
  - brValid during FLUSH is ignored, since that instruction is squashed.
- pcTarget always shows the latched target register. It is meaningful only while pcSel=1.
- Latency, no hazard: accept at cycle N, RESOLVE/redirect at N+1, flush at N+2 .. N+1+FLUSH_CYCLES. A new accept is possible at N+2 when not taken, or at N+2+FLUSH_CYCLES when taken.
- Back-to-back: a branch presented in IDLE the cycle after a not-taken RESOLVE is accepted normally.
- Outputs pcSel, stall and cmpOp are combinational decodes of state plus inputs. State, counters and hazErr are registered.

Test Plan:
- Reset mid-HOLD: accept brOpIn=10 with opBusy=1, hold 3 cycles, then assert rst -> next cycle state IDLE, stall=0, cmpOp=00, counters 0, hazErr=0.
- Taken equal, no hazard: brValid=1, brOpIn=10, brTarget=16'h0040, opBusy=0; comparator returns jmpTrue=1 -> stall=1 at N; at N+1 cmpOp=10, pcSel=1, pcTarget=16'h0040; flush=1 at N+2 only (FLUSH_CYCLES=1); brCount=1, takenCount=1.
- Not-taken greater-than with hazard: brOpIn=11, opBusy=1 for 4 cycles then 0; jmpTrue=0 -> stall held 6 cycles (accept + 4 HOLD + RESOLVE), pcSel never 1, flush never 1, brCount=1, takenCount=0.
- HOLD timeout: HOLD_LIMIT=3, opBusy stuck 1 -> after 3 HOLD cycles return to IDLE, hazErr=1 and stays 1, brCount=0; a later branch still resolves normally.
- Ignored requests: brOpIn=00 with brValid=1 -> no stall, no count. A branch presented during FLUSH (FLUSH_CYCLES=2) -> not accepted, counters unchanged.
- Saturation: preload via 65535 resolved taken branches (or force) -> brCount and takenCount remain 16'hFFFF on the next taken branch.
